// File: rtl/ov7670_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ov7670_pkg
// Description : Shared definitions for the OV7670 stream generator: pattern
//               mode encodings, the eight RGB565 colour-bar values, counter
//               widths and the frame FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

    // Pattern select encodings, as seen on the mode input
    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // Colour bars left to right; element 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_COLORS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    // Counter widths; the timing parameters must fit inside these
    localparam int BYTE_CNT_W = 11;
    localparam int LINE_CNT_W = 10;
    localparam int X_W        = BYTE_CNT_W - 1;

    // Frame FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ov7670_pixel_pattern.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ov7670_pixel_pattern
// Description : Combinational RGB565 test-pattern generator.
//               mode        - pattern select (bars, ramp, constant, checker)
//               x, y        - pixel column and line inside the active window
//               const_color - colour used by the constant pattern
//               frame_odd   - bit 0 of the completed-frame count
//               pix         - RGB565 pixel value
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_pixel_pattern
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [1:0]            mode,
    input  logic [X_W-1:0]        x,
    input  logic [LINE_CNT_W-1:0] y,
    input  logic [15:0]           const_color,
    input  logic                  frame_odd,
    output logic [15:0]           pix
);

    localparam int c_BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar;
    logic       w_unused_y;

    // Only y[5] drives the checker; the rest of the line index is unused
    assign w_unused_y = ^{y[LINE_CNT_W-1:6], y[4:0]};

    // Bar index by threshold comparison, avoiding a divider on x
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= X_W'(i * c_BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    always_comb begin
        pix = 16'h0000;
        case (mode)
            MODE_BARS:  pix = BAR_COLORS[w_bar];
            MODE_RAMP:  pix = {x[7:3], x[7:2], x[7:3]};
            MODE_CONST: pix = const_color;
            MODE_CHECK: pix = (x[5] ^ y[5] ^ frame_odd) ? 16'hFFFF : 16'h0000;
            default:    pix = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ov7670_stream_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ov7670_stream_gen
// Description : OV7670 camera-bus emulator. Produces pclk/vsync/href/d with
//               VGA-style frame timing carrying RGB565 test patterns.
//               clk, reset       - system clock, synchronous active-high reset
//               enable           - run request, sampled at frame boundaries
//               mode/const_color - pattern select and constant colour
//               pclk             - pixel clock, clk/2
//               vsync, href, d   - camera bus; d carries high byte first
//               frame_done       - one-clk pulse at the end of each frame
//               frame_count      - completed frames, wraps at 256
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] const_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam logic [BYTE_CNT_W-1:0] c_LINE_LAST   = BYTE_CNT_W'(2 * H_TOTAL - 1);
    localparam logic [BYTE_CNT_W-1:0] c_HREF_END    = BYTE_CNT_W'(2 * H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] c_SYNC_LAST   = LINE_CNT_W'(V_SYNC - 1);
    localparam logic [LINE_CNT_W-1:0] c_BACK_LAST   = LINE_CNT_W'(V_BACK - 1);
    localparam logic [LINE_CNT_W-1:0] c_ACTIVE_LAST = LINE_CNT_W'(V_ACTIVE - 1);
    localparam logic [LINE_CNT_W-1:0] c_FRONT_LAST  = LINE_CNT_W'(V_FRONT - 1);

    state_t                r_state;
    logic                  r_pclk;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic [1:0]            r_mode;
    logic [15:0]           r_const;
    logic                  r_vsync;
    logic                  r_href;
    logic [7:0]            r_d;
    logic                  r_done_pend;
    logic                  r_frame_done;
    logic [7:0]            r_frame_count;

    logic                  w_rise;
    logic                  w_line_end;
    logic                  w_phase_last;
    logic                  w_href_next;
    logic [15:0]           w_pix;
    logic [7:0]            w_byte;

    // pclk is low before this edge, so this edge drives it high
    assign w_rise      = ~r_pclk;
    assign w_line_end  = (r_byte_cnt == c_LINE_LAST);
    assign w_href_next = (r_state == ST_ACTIVE) && (r_byte_cnt < c_HREF_END);
    assign w_byte      = r_byte_cnt[0] ? w_pix[7:0] : w_pix[15:8];

    // Last line of the current vertical phase
    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            ST_VSYNC:  w_phase_last = (r_line_cnt == c_SYNC_LAST);
            ST_VBACK:  w_phase_last = (r_line_cnt == c_BACK_LAST);
            ST_ACTIVE: w_phase_last = (r_line_cnt == c_ACTIVE_LAST);
            ST_VFRONT: w_phase_last = (r_line_cnt == c_FRONT_LAST);
            default:   w_phase_last = 1'b0;
        endcase
    end

    ov7670_pixel_pattern #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .mode        (r_mode),
        .x           (r_byte_cnt[BYTE_CNT_W-1:1]),
        .y           (r_line_cnt),
        .const_color (r_const),
        .frame_odd   (r_frame_count[0]),
        .pix         (w_pix)
    );

    // Bus outputs are registered from the slot the counters point at, so
    // every output trails the counters by one pclk. frame_done follows the
    // same one-slot lag: it fires as the final blank slot of the frame ends,
    // which is also where the next frame's vsync would rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pclk        <= 1'b0;
            r_byte_cnt    <= '0;
            r_line_cnt    <= '0;
            r_mode        <= MODE_BARS;
            r_const       <= 16'h0000;
            r_vsync       <= 1'b0;
            r_href        <= 1'b0;
            r_d           <= 8'h00;
            r_done_pend   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'h00;
        end else begin
            r_pclk       <= ~r_pclk;
            r_frame_done <= 1'b0;
            if (w_rise) begin
                r_vsync      <= (r_state == ST_VSYNC);
                r_href       <= w_href_next;
                r_d          <= w_href_next ? w_byte : 8'h00;
                r_frame_done <= r_done_pend;
                r_done_pend  <= 1'b0;
                if (r_done_pend) begin
                    r_frame_count <= r_frame_count + 8'd1;
                end

                if (r_state == ST_IDLE) begin
                    r_byte_cnt <= '0;
                    r_line_cnt <= '0;
                    if (enable) begin
                        r_mode  <= mode;
                        r_const <= const_color;
                        r_state <= ST_VSYNC;
                    end
                end else if (!w_line_end) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end else begin
                    r_byte_cnt <= '0;
                    if (!w_phase_last) begin
                        r_line_cnt <= r_line_cnt + 1'b1;
                    end else begin
                        r_line_cnt <= '0;
                        case (r_state)
                            ST_VSYNC:  r_state <= ST_VBACK;
                            ST_VBACK:  r_state <= ST_ACTIVE;
                            ST_ACTIVE: r_state <= ST_VFRONT;
                            ST_VFRONT: begin
                                // Only frame boundary where enable is honoured
                                // outside IDLE; mode is not re-latched here.
                                r_done_pend <= 1'b1;
                                r_state     <= enable ? ST_VSYNC : ST_IDLE;
                            end
                            default:   r_state <= ST_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign pclk        = r_pclk;
    assign vsync       = r_vsync;
    assign href        = r_href;
    assign d           = r_d;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_stream_gen
// Description : Self-checking bench for ov7670_stream_gen. A stimulus
//               process runs frames with randomised patterns and pushes the
//               expected active-window bytes into a queue; a monitor
//               samples the bus once per pclk and checks bytes, blanking,
//               line/frame timing and the frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_stream_gen;

    localparam int TB_H_ACTIVE = 64;
    localparam int TB_H_TOTAL  = 68;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BACK   = 1;
    localparam int TB_V_ACTIVE = 34;
    localparam int TB_V_FRONT  = 1;

    localparam int LINE  = 2 * TB_H_TOTAL;
    localparam int FRAME = (TB_V_SYNC + TB_V_BACK + TB_V_ACTIVE + TB_V_FRONT) * LINE;
    localparam int DONE_BUDGET = 2 * FRAME + 100;
    localparam int HREF_BUDGET = 2 * (TB_V_SYNC + TB_V_BACK + 1) * LINE + 100;

    localparam logic [1:0] M_BARS  = 2'd0;
    localparam logic [1:0] M_RAMP  = 2'd1;
    localparam logic [1:0] M_CONST = 2'd2;
    localparam logic [1:0] M_CHECK = 2'd3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] const_color;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;
    logic [7:0]  frame_count;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [7:0]  exp_q[$];
    int          model_fc;
    logic [15:0] bar_colors [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                      16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    ov7670_stream_gen #(
        .H_ACTIVE (TB_H_ACTIVE),
        .H_TOTAL  (TB_H_TOTAL),
        .V_SYNC   (TB_V_SYNC),
        .V_BACK   (TB_V_BACK),
        .V_ACTIVE (TB_V_ACTIVE),
        .V_FRONT  (TB_V_FRONT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .const_color (const_color),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        assert (TB_H_ACTIVE % 8 == 0 && TB_H_TOTAL > TB_H_ACTIVE &&
                2 * TB_H_TOTAL <= 2048 && TB_V_SYNC <= 1024 && TB_V_BACK <= 1024 &&
                TB_V_ACTIVE <= 1024 && TB_V_FRONT <= 1024)
        else begin
            $display("FAIL params: timing parameters exceed the counter widths");
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference pattern, straight from the pattern rules
    function automatic logic [15:0] ref_pix(input logic [1:0] m, input int x, input int y,
                                            input logic [15:0] cc, input int fc);
        int r, g;
        case (m)
            M_BARS:  return bar_colors[x / (TB_H_ACTIVE / 8)];
            M_RAMP:  begin
                r = (x / 8) % 32;
                g = (x / 4) % 64;
                return 16'(r * 2048 + g * 32 + r);
            end
            M_CONST: return cc;
            default: return ((((x / 32) + (y / 32) + fc) % 2) == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [15:0] cc, input int fc);
        logic [15:0] p;
        for (int y = 0; y < TB_V_ACTIVE; y++) begin
            for (int x = 0; x < TB_H_ACTIVE; x++) begin
                p = ref_pix(m, x, y, cc, fc);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    // what: 0 vsync high, 1 frame_done high, 2 href high
    task automatic wait_for(input int what, input int budget, input string name);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (what)
                0:       hit = (vsync === 1'b1);
                1:       hit = (frame_done === 1'b1);
                default: hit = (href === 1'b1);
            endcase
        end
        n_total++;
        if (hit) n_pass++;
        else $display("FAIL wait_%s: event not seen within %0d clk", name, budget);
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle_vsync", vsync, 0);
            check("idle_href", href, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pclk"}, pclk, 0);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_href"}, href, 0);
        check({tag, "_d"}, d, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    // ---------------- monitor: one sample per pclk, just after each clk edge
    int unsigned slot, vs_rise, href_rise, href_cnt, mon_fc;
    logic        prev_vs, prev_href, last_pclk;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            slot = 0; vs_rise = 0; href_rise = 0; href_cnt = 0; mon_fc = 0;
            prev_vs = 1'b0; prev_href = 1'b0; last_pclk = 1'b0;
        end else begin
            check("pclk_toggle", pclk, !last_pclk);
            last_pclk = pclk;
            if (!pclk) begin
                check("done_width", frame_done, 0);
            end else begin
                slot++;
                if (frame_done) begin
                    mon_fc = (mon_fc + 1) % 256;
                    check("frame_len", slot - vs_rise, FRAME);
                    check("lines_per_frame", href_cnt, TB_V_ACTIVE);
                    check("frame_count", frame_count, mon_fc);
                    check("bytes_left", exp_q.size(), 0);
                end
                if (vsync && !prev_vs) begin
                    vs_rise  = slot;
                    href_cnt = 0;
                end
                if (!vsync && prev_vs) check("vsync_len", slot - vs_rise, TB_V_SYNC * LINE);
                if (href && !prev_href) begin
                    if (href_cnt == 0)
                        check("first_href", slot - vs_rise, (TB_V_SYNC + TB_V_BACK) * LINE);
                    else
                        check("line_period", slot - href_rise, LINE);
                    href_rise = slot;
                    href_cnt++;
                end
                if (!href && prev_href) check("href_len", slot - href_rise, 2 * TB_H_ACTIVE);
                if (href) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL pixel_byte: got 0x%0h, expected no byte (queue empty) at %0t",
                                 d, $time);
                    end else begin
                        check("pixel_byte", d, exp_q.pop_front());
                    end
                end else begin
                    check("d_blank", d, 0);
                end
                prev_vs   = vsync;
                prev_href = href;
            end
        end
    end

    // ---------------- stimulus
    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        mode        = M_BARS;
        const_color = 16'h1234;
        model_fc    = 0;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");

        // Frame 0: colour bars, started straight out of reset
        push_frame(M_BARS, const_color, model_fc);
        reset = 1'b0;
        wait_for(0, 4, "vsync_after_reset");
        enable      = 1'b0;
        mode        = 2'($urandom_range(1, 3));
        const_color = 16'($urandom);
        wait_for(1, DONE_BUDGET, "f0_done");
        model_fc++;
        idle_check(40);

        // Frames 1 and 2 back to back in checker mode; inputs changed
        // mid-frame must not be picked up by the second frame
        mode        = M_CHECK;
        const_color = 16'($urandom);
        push_frame(M_CHECK, const_color, model_fc);
        enable = 1'b1;
        wait_for(0, 6, "f1_vsync");
        mode        = 2'($urandom_range(0, 2));
        const_color = 16'($urandom);
        wait_for(1, DONE_BUDGET, "f1_done");
        model_fc++;
        enable = 1'b0;
        push_frame(M_CHECK, const_color, model_fc);
        wait_for(1, DONE_BUDGET, "f2_done");
        model_fc++;
        idle_check(20);

        // Frames 3 and 4: ramp and constant, enable dropped mid-active
        for (int k = 0; k < 2; k++) begin
            mode        = (k == 0) ? M_RAMP : M_CONST;
            const_color = 16'($urandom);
            push_frame(mode, const_color, model_fc);
            enable = 1'b1;
            wait_for(2, HREF_BUDGET, "f34_href");
            repeat ($urandom_range(1, 300)) @(negedge clk);
            enable      = 1'b0;
            mode        = 2'($urandom);
            const_color = 16'($urandom);
            wait_for(1, DONE_BUDGET, "f34_done");
            model_fc++;
            idle_check(40);
        end

        // Frame 5: random pattern, aborted by a reset in the middle of href
        mode        = 2'($urandom);
        const_color = 16'($urandom);
        push_frame(mode, const_color, model_fc);
        enable = 1'b1;
        wait_for(2, HREF_BUDGET, "f5_href");
        repeat ($urandom_range(1, 100)) @(negedge clk);
        check("pre_reset_href", href, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        model_fc = 0;

        // Frame 6: fresh checker frame after reset, frame parity back to 0
        mode        = M_CHECK;
        const_color = 16'($urandom);
        push_frame(M_CHECK, const_color, model_fc);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_for(0, 4, "vsync_after_midrst");
        enable = 1'b0;
        wait_for(1, DONE_BUDGET, "f6_done");
        idle_check(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
Synthesizable OV7670 camera emulator. It drives the same pclk/vsync/href/d[7:0] pixel bus that the camera presents to the capture path, carrying RGB565 test patterns with OV7670-style VGA frame timing. It lets the capture, frame-buffer and VGA path be tested in simulation and on the board without a physical sensor. The block sits in place of the camera pins, with its outputs wired straight into the capture block inputs.

Parameters:
H_ACTIVE, 640, active pixels per line (2 bytes each); must be a multiple of 8.
H_TOTAL, 784, total pixel slots per line including blanking; must be greater than H_ACTIVE.
V_SYNC, 3, lines with vsync high.
V_BACK, 17, blank lines after vsync, before the first active line.
V_ACTIVE, 480, active lines per frame.
V_FRONT, 10, blank lines after the last active line.

Ports:
clk  in  1  system clock; pclk is derived from it at clk/2.
reset  in  1  synchronous, active-high reset.
enable  in  1  run request; sampled only at frame boundaries.
mode  in  2  pattern select: 0 colour bars, 1 grey ramp, 2 constant, 3 checker.
const_color  in  16  RGB565 value used by mode 2.
pclk  out  1  pixel clock, clk/2.
vsync  out  1  frame sync, active high.
href  out  1  line valid, active high.
d  out  8  pixel byte; high byte of each pixel first.
frame_done  out  1  one-clk pulse at the end of each frame.
frame_count  out  8  completed frames, wraps 255 to 0.

Behaviour:
- Reset, while reset=1: pclk=0, vsync=0, href=0, d=0, frame_done=0, frame_count=0; state=IDLE; all counters cleared. Reset overrides everything, including mid-line and mid-frame; there is no partial-frame completion.
- Pixel clock: pclk toggles every clk while reset=0, in every state including IDLE.
- Rise tick: the clk edge on which pclk goes 0 to 1. All other registers (state, counters, vsync, href, d) update only on rise ticks. Outputs therefore change with pclk rising and are stable at pclk falling, which is where the capture side samples.
- Counters:
  - byte_cnt: 0 to 2*H_TOTAL-1, 11 bits, wraps at end of line.
  - line_cnt: 10 bits, cleared on every state change.
- FSM, evaluated on rise ticks:
  - IDLE: if enable=1, latch mode and const_color, then go to VSYNC. Latched values are held for the whole frame.
  - VSYNC: vsync=1 for V_SYNC full lines, then go to VBACK.
  - VBACK: V_BACK blank lines, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. href=1 for byte_cnt 0 to 2*H_ACTIVE-1, otherwise 0. Go to VFRONT after the last line.
  - VFRONT: V_FRONT blank lines. At the end: pulse frame_done, increment frame_count, then go to VSYNC if enable=1, else IDLE.
- Enable deasserted mid-frame: the current frame completes in full; it is only checked at the VFRONT exit and in IDLE.
- Data: d=0 whenever href=0. With x = byte_cnt>>1 and y = line_cnt, even byte_cnt carries pix[15:8] and odd byte_cnt carries pix[7:0].
- Patterns:
  - mode 0: 8 equal bars of width H_ACTIVE/8, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mode 1: pix = {x[7:3], x[7:2], x[7:3]}.
  - mode 2: pix = latched const_color.
  - mode 3: pix = FFFF if (x[5]^y[5]^frame_count[0]), else 0000.
- Cycle counts:
  - First vsync=1 appears on the first rise tick after the IDLE rise tick that sampled enable=1.
  - Line length: 2*H_TOTAL pclk.
  - Frame length: (V_SYNC+V_BACK+V_ACTIVE+V_FRONT)*2*H_TOTAL pclk.
- Width rules: parameters larger than the counter widths are illegal. The bench asserts on them; the RTL does not handle them.

Decomposition:
- Shared package ov7670_pkg holds:
  - mode encodings MODE_BARS, MODE_RAMP, MODE_CONST, MODE_CHECK;
  - the eight RGB565 bar colours;
  - FSM state encodings.
- One combinational sub-module, ov7670_pixel_pattern, maps (mode, x, y, const_color, frame_count[0]) to pix[15:0]. Timing and the FSM stay in the top block.

Test Plan:
1. Reset: assert reset for 5 clk with enable=1 -> all outputs 0; once released, pclk toggles every clk and vsync rises within 2 pclk.
2. Small frame: H_ACTIVE=8, H_TOTAL=12, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 -> vsync high 24 pclk; exactly 2 href pulses of 16 pclk each; frame_done after 120 pclk; frame_count=1.
3. Colour bars, same small params: line bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
4. Loopback into the capture block at default params, mode 2 with const_color=F800 -> write address reaches the expected count per frame; written data is F00 (12-bit).
5. Deassert enable mid-ACTIVE -> the frame completes with all V_ACTIVE lines, frame_done pulses, the block returns to IDLE, and vsync stays 0 afterwards.
6. Reset pulse mid-href -> href and d drop to 0 on the next clk; after release, a fresh frame restarts with frame_count=0.
